unified_mem_arbiter: RTL and testbench

Arbiter and sequencer sharing one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Grants one requester at a time, drives the external memory handshake, and returns read data with a one-cycle acknowledge. Exports per-stage stall signals that the hazard logic uses to freeze fetch or memory while their access is outstanding.

---
 rtl/unified_mem_arbiter_pkg.sv | 14 +
 rtl/unified_mem_arbiter_starve_counter.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and default bus widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// arb_starve_counter: counts data grants made while fetch waits; o_hit when the count reaches LIMIT.
// Latency: count updates on the grant edge; o_hit is combinational from the count. No backpressure.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_hit) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_hit = (r_cnt == 4'(LIMIT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-ported memory shared by fetch and data; data wins, fetch is never preempted.
// Latency: mem_req one cycle after grant, ack one cycle after mem_ready; requesters stall until ack.
// Optional fetch starvation guard enabled by MEM_ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_done;
    logic              w_starve_hit;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ack;
    logic              r_dm_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starve_inc;

    assign w_starve_inc = w_grant_dm & if_req;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_starve_inc),
        .i_clr (w_grant_if),
        .o_hit (w_starve_hit)
    );
`else
    assign w_starve_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_grant_dm   = 1'b0;
        w_grant_if   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                // Starvation hit only overrides data when fetch is actually waiting.
                if (dm_req && !(w_starve_hit && if_req)) begin
                    w_grant_dm   = 1'b1;
                    w_next_state = DM_ACC;
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = IF_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (w_grant_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_if) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= if_addr;
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_state == IF_ACC) begin
                    r_if_rdata <= mem_rdata;
                    r_if_ack   <= 1'b1;
                end else begin
                    r_dm_ack <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign stall_f   = if_req & ~r_if_ack;
    assign stall_m   = dm_req & ~r_dm_ack;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed timing scenarios plus a randomized
// run against a transaction-level model; build with MEM_ARB_STARVE_GUARD_EN for the guard variant.
module tb_unified_mem_arbiter;

    localparam int LIM = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_f;
    logic        stall_m;
    logic        busy;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int wait_left = -1;
    int fixed_wait = 0;
    bit rand_wait = 1'b0;
    logic [31:0] exp_dm_rdata = '0;
    logic [31:0] mem_m [logic [31:0]];

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .busy      (busy)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory side: answers mem_req after a configured or random number of wait cycles.
    task automatic respond();
        if (mem_req) begin
            if (wait_left < 0) wait_left = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_we ? $urandom : rd(mem_addr);
                if (mem_we) mem_m[mem_addr] = mem_wdata;
                wait_left = -1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wait_left = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        rst = 1'b0;
        exp_dm_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({mem_req, mem_we, if_ack, dm_ack, busy, stall_f, stall_m} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_ctrl: got=%b want=0000000", {mem_req, mem_we, if_ack, dm_ack, busy, stall_f, stall_m});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            n_err++;
            $display("FAIL rst_data: got=%h want=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        fixed_wait = 0;
        mem_m[32'h10] = 32'h0050_0093;
        if_req = 1'b1;
        if_addr = 32'h10;
        #1;
        n_checks++;
        if (stall_f !== 1'b1) begin n_err++; $display("FAIL sf_stall0: got=%b want=1", stall_f); end
        step();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, if_ack} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
            n_err++;
            $display("FAIL sf_c1: got req=%b we=%b addr=%h ack=%b want 1 0 10 0", mem_req, mem_we, mem_addr, if_ack);
        end
        step();
        n_checks++;
        if ({if_ack, if_rdata, stall_f, mem_req} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sf_c2: got ack=%b rdata=%h stall_f=%b req=%b want 1 00500093 0 0", if_ack, if_rdata, stall_f, mem_req);
        end
        if_req = 1'b0;
        step();
        n_checks++;
        if ({busy, if_ack} !== 2'b00) begin n_err++; $display("FAIL sf_c3: got busy/ack=%b want 00", {busy, if_ack}); end
    endtask

    task automatic test_store_wait();
        fixed_wait = 4;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, dm_ack, stall_m} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL st_hold c%0d: got req=%b we=%b addr=%h wdata=%h ack=%b stall=%b want 1 1 100 deadbeef 0 1",
                         i, mem_req, mem_we, mem_addr, mem_wdata, dm_ack, stall_m);
            end
        end
        step();
        n_checks++;
        if ({dm_ack, dm_rdata, stall_m, mem_req, mem_we} !== {1'b1, exp_dm_rdata, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL st_ack: got ack=%b rdata=%h stall=%b req=%b we=%b want 1 %h 0 0 0", dm_ack, dm_rdata, stall_m, mem_req, mem_we, exp_dm_rdata);
        end
        dm_req = 1'b0;
        step();
        n_checks++;
        if ({dm_ack, busy} !== 2'b00) begin n_err++; $display("FAIL st_end: got ack/busy=%b want 00", {dm_ack, busy}); end
    endtask

    task automatic test_simultaneous();
        fixed_wait = 0;
        mem_m[32'h200] = 32'hCAFE_0001;
        mem_m[32'h20] = 32'h1111_2222;
        if_req = 1'b1;
        if_addr = 32'h20;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h200;
        step();
        n_checks++;
        if ({mem_req, mem_addr, mem_we, stall_f} !== {1'b1, 32'h200, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sim_c1: got req=%b addr=%h we=%b stall_f=%b want 1 200 0 1", mem_req, mem_addr, mem_we, stall_f);
        end
        step();
        n_checks++;
        if ({dm_ack, dm_rdata, if_ack, stall_f} !== {1'b1, 32'hCAFE_0001, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sim_c2: got dm_ack=%b dm_rdata=%h if_ack=%b stall_f=%b want 1 cafe0001 0 1", dm_ack, dm_rdata, if_ack, stall_f);
        end
        exp_dm_rdata = 32'hCAFE_0001;
        dm_req = 1'b0;
        step();
        n_checks++;
        if ({mem_req, busy, stall_f} !== 3'b001) begin n_err++; $display("FAIL sim_c3: got req/busy/stall_f=%b want 001", {mem_req, busy, stall_f}); end
        step();
        n_checks++;
        if ({mem_req, mem_addr, mem_we} !== {1'b1, 32'h20, 1'b0}) begin
            n_err++;
            $display("FAIL sim_c4: got req=%b addr=%h we=%b want 1 20 0", mem_req, mem_addr, mem_we);
        end
        step();
        n_checks++;
        if ({if_ack, if_rdata, stall_f} !== {1'b1, 32'h1111_2222, 1'b0}) begin
            n_err++;
            $display("FAIL sim_c5: got ack=%b rdata=%h stall_f=%b want 1 11112222 0", if_ack, if_rdata, stall_f);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_mid_fetch();
        bit got = 1'b0;
        fixed_wait = 2;
        if_req = 1'b1;
        if_addr = 32'h30;
        step();
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h204;
        for (int i = 2; i <= 3; i++) begin
            step();
            n_checks++;
            if ({mem_req, mem_addr} !== {1'b1, 32'h30}) begin
                n_err++;
                $display("FAIL mf_hold c%0d: got req=%b addr=%h want 1 30", i, mem_req, mem_addr);
            end
        end
        step();
        n_checks++;
        if ({if_ack, if_rdata, dm_ack, stall_m} !== {1'b1, rd(32'h30), 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mf_fack: got if_ack=%b rdata=%h dm_ack=%b stall_m=%b want 1 %h 0 1", if_ack, if_rdata, dm_ack, stall_m, rd(32'h30));
        end
        if_req = 1'b0;
        step();
        step();
        n_checks++;
        if ({mem_req, mem_addr, mem_we} !== {1'b1, 32'h204, 1'b0}) begin
            n_err++;
            $display("FAIL mf_dgrant: got req=%b addr=%h we=%b want 1 204 0", mem_req, mem_addr, mem_we);
        end
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            got = dm_ack;
        end
        n_checks++;
        if (!got || dm_rdata !== rd(32'h204)) begin
            n_err++;
            $display("FAIL mf_dack: got ack_seen=%b rdata=%h want 1 %h", got, dm_rdata, rd(32'h204));
        end
        exp_dm_rdata = rd(32'h204);
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        fixed_wait = 100;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h44;
        dm_wdata = 32'h1234_5678;
        step();
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h44}) begin
            n_err++;
            $display("FAIL rm_pre: got req=%b we=%b addr=%h want 1 1 44", mem_req, mem_we, mem_addr);
        end
        step();
        step();
        rst = 1'b1;
        dm_req = 1'b0;
        step();
        rst = 1'b0;
        n_checks++;
        if ({busy, mem_req, mem_we, if_ack, dm_ack} !== 5'b0) begin
            n_err++;
            $display("FAIL rm_ctrl: got busy/req/we/ifack/dmack=%b want 00000", {busy, mem_req, mem_we, if_ack, dm_ack});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            n_err++;
            $display("FAIL rm_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        exp_dm_rdata = '0;
        step();
    endtask

    task automatic test_starvation();
        int grants = 0;
        int scnt = 0;
        bit prev_req = 1'b0;
        bit exp_f;
        bit got_f;
        do_reset();
        fixed_wait = 0;
        if_req = 1'b1;
        if_addr = 32'h40;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h300;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            step();
            if (mem_req && !prev_req) begin
                got_f = (mem_addr == 32'h40);
                exp_f = STARVE_ON && (scnt == LIM);
                scnt = exp_f ? 0 : scnt + 1;
                n_checks++;
                if (got_f !== exp_f) begin
                    n_err++;
                    $display("FAIL sv_order grant%0d: got fetch=%b want fetch=%b", grants, got_f, exp_f);
                end
                grants++;
            end
            prev_req = mem_req;
        end
        n_checks++;
        if (grants != 6) begin n_err++; $display("FAIL sv_grants: got=%0d want=6", grants); end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_random();
        int phase = 0;
        int scnt = 0;
        int n_acc = 0;
        bit own_dm = 1'b0;
        bit p_if = 1'b0;
        bit p_dm = 1'b0;
        bit p_done = 1'b0;
        logic [31:0] exp_rd = '0;
        logic [31:0] g_addr = '0;
        logic [31:0] g_wdata = '0;
        bit g_we = 1'b0;
        do_reset();
        rand_wait = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            cyc++;
            if (phase == 2) begin
                phase = 0;
            end else if (phase == 1) begin
                if (p_done) phase = 2;
            end else if (p_if || p_dm) begin
                own_dm = p_dm && !(STARVE_ON && scnt == LIM && p_if);
                if (!own_dm) scnt = 0;
                else if (p_if) scnt++;
                phase = 1;
                n_acc++;
                g_addr = own_dm ? dm_addr : if_addr;
                g_we = own_dm && dm_we;
                g_wdata = dm_wdata;
            end
            n_checks++;
            if ({busy, mem_req, if_ack, dm_ack} !== {phase != 0, phase == 1, phase == 2 && !own_dm, phase == 2 && own_dm}) begin
                n_err++;
                $display("FAIL rnd_ctrl cyc%0d: got busy/req/ifack/dmack=%b want %b", cyc, {busy, mem_req, if_ack, dm_ack},
                         {phase != 0, phase == 1, phase == 2 && !own_dm, phase == 2 && own_dm});
            end
            if (phase == 1) begin
                n_checks++;
                if ({mem_addr, mem_we} !== {g_addr, g_we} || (g_we && mem_wdata !== g_wdata)) begin
                    n_err++;
                    $display("FAIL rnd_bus cyc%0d: got addr=%h we=%b wdata=%h want %h %b %h", cyc, mem_addr, mem_we, mem_wdata, g_addr, g_we, g_wdata);
                end
            end
            if (phase == 2) begin
                n_checks++;
                if ((!own_dm && if_rdata !== exp_rd) || (own_dm && dm_rdata !== exp_dm_rdata)) begin
                    n_err++;
                    $display("FAIL rnd_rdata cyc%0d: got if=%h dm=%h want %h (data=%b)", cyc, if_rdata, dm_rdata, own_dm ? exp_dm_rdata : exp_rd, own_dm);
                end
            end
            n_checks++;
            if ({stall_f, stall_m} !== {if_req & ~if_ack, dm_req & ~dm_ack}) begin
                n_err++;
                $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, {stall_f, stall_m}, {if_req & ~if_ack, dm_req & ~dm_ack});
            end
            respond();
            p_done = (phase == 1) && mem_ready;
            if (p_done) begin
                exp_rd = mem_rdata;
                if (own_dm && !g_we) exp_dm_rdata = mem_rdata;
            end
            if (if_ack) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (dm_ack) begin
                dm_req = 1'b0;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'($urandom_range(0, 15)) << 2;
                dm_wdata = $urandom;
            end
            p_if = if_req;
            p_dm = dm_req;
        end
        n_checks++;
        if (n_acc < 20) begin n_err++; $display("FAIL rnd_activity: got %0d accesses want >= 20", n_acc); end
        if_req = 1'b0;
        dm_req = 1'b0;
        rand_wait = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_simultaneous();
        test_mid_fetch();
        test_reset_mid_access();
        test_starvation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
